// File: rtl/if_stage_pkg.sv
// Shared widths, reset PC and FSM encoding for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned FS_TO_DS_BUS_WD = 64;
  localparam int unsigned BR_BUS_WD       = 33;
  localparam logic [31:0] RESET_PC        = 32'h1c000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fs_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: nextpc selection, single-outstanding SRAM fetch FSM
// and a one-entry instruction buffer feeding decode.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  input  logic                       fs_flush_pipe,
  input  logic [31:0]                ex_target,
  output logic                       inst_sram_req,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  fs_state_e   r_state;
  fs_state_e   w_state_nxt;
  logic        r_fs_valid;
  logic [31:0] r_fs_pc;
  logic [31:0] r_inst_buf;
  logic        r_inst_buf_valid;
  logic [31:0] r_req_pc;
  logic        r_rd_valid;
  logic        r_rd_flush;
  logic [31:0] r_rd_target;
  logic        r_cancel;

  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic        w_redirect;
  logic        w_fs_ready_go;
  logic        w_fs_allowin;
  logic [31:0] w_nextpc;
  logic        w_issue;
  logic        w_data_ok_wait;
  logic        w_data_accept;
  logic        w_handoff;
  logic        w_cancel_set;

  assign w_br_taken    = br_bus[32];
  assign w_br_target   = br_bus[31:0];
  assign w_redirect    = fs_flush_pipe | w_br_taken;
  assign w_fs_ready_go = r_inst_buf_valid;
  assign w_fs_allowin  = !r_fs_valid || (w_fs_ready_go && ds_allowin);

  // Flush beats a buffered redirect, which beats a fresh branch.
  assign w_nextpc = fs_flush_pipe ? ex_target   :
                    r_rd_valid    ? r_rd_target :
                    w_br_taken    ? w_br_target :
                                    r_fs_pc + 32'd4;

  // Requests are only launched from S_IDLE once the buffer is free this cycle.
  assign w_issue        = resetn && (r_state == S_IDLE) && w_fs_allowin;
  assign w_data_ok_wait = (r_state == S_WAIT) && inst_sram_data_ok;
  assign w_data_accept  = w_data_ok_wait && !r_cancel && !w_redirect;
  assign w_handoff      = fs_to_ds_valid && ds_allowin;

  // A stale request already accepted by the SRAM must have its data dropped.
  assign w_cancel_set = ((r_state == S_WAIT) && !inst_sram_data_ok && w_redirect) ||
                        ((r_state == S_REQ) && inst_sram_addr_ok && (w_redirect || r_rd_valid));

  assign fs_to_ds_valid = r_fs_valid && w_fs_ready_go && !fs_flush_pipe && !w_br_taken;
  assign fs_to_ds_bus   = {r_inst_buf, r_fs_pc};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    inst_sram_req  = 1'b0;
    inst_sram_addr = w_nextpc;
    case (r_state)
      S_IDLE: begin
        inst_sram_req = w_issue;
        if (w_issue) begin
          w_state_nxt = inst_sram_addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        inst_sram_req  = 1'b1;
        inst_sram_addr = r_req_pc;
        if (inst_sram_addr_ok) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fs_valid       <= 1'b0;
      r_fs_pc          <= RESET_PC - 32'd4;
      r_inst_buf       <= '0;
      r_inst_buf_valid <= 1'b0;
      r_req_pc         <= '0;
      r_rd_valid       <= 1'b0;
      r_rd_flush       <= 1'b0;
      r_rd_target      <= '0;
      r_cancel         <= 1'b0;
    end else begin
      if (w_issue) begin
        r_req_pc <= w_nextpc;
      end

      if (w_cancel_set) begin
        r_cancel <= 1'b1;
      end else if (w_data_ok_wait) begin
        r_cancel <= 1'b0;
      end

      // Redirects that cannot drive the address right now wait here.
      if (w_issue) begin
        r_rd_valid <= 1'b0;
        r_rd_flush <= 1'b0;
      end else if (fs_flush_pipe) begin
        r_rd_valid  <= 1'b1;
        r_rd_flush  <= 1'b1;
        r_rd_target <= ex_target;
      end else if (w_br_taken && !(r_rd_valid && r_rd_flush)) begin
        r_rd_valid  <= 1'b1;
        r_rd_flush  <= 1'b0;
        r_rd_target <= w_br_target;
      end

      if (w_data_accept) begin
        r_fs_valid       <= 1'b1;
        r_inst_buf_valid <= 1'b1;
        r_fs_pc          <= r_req_pc;
        r_inst_buf       <= inst_sram_rdata;
      end else if (w_handoff || w_redirect) begin
        r_fs_valid       <= 1'b0;
        r_inst_buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small instruction-SRAM responder model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic                       clk = 1'b0;
  logic                       resetn;
  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       fs_flush_pipe;
  logic [31:0]                ex_target;
  logic                       inst_sram_req;
  logic [31:0]                inst_sram_addr;
  logic                       inst_sram_addr_ok = 1'b0;
  logic                       inst_sram_data_ok = 1'b0;
  logic [31:0]                inst_sram_rdata   = 32'h0;

  int n_chk = 0;
  int n_err = 0;

  logic        aok_en;
  int          dok_lat;
  logic        pend      = 1'b0;
  int          pend_cnt  = 0;
  logic [31:0] pend_addr = 32'h0;
  logic        hs        = 1'b0;
  logic [31:0] hs_addr   = 32'h0;
  logic [31:0] q_req[$];
  logic [63:0] q_dlv[$];

  logic [31:0] exp_req [8] = '{32'h1c000000, 32'h1c000004, 32'h1c000008, 32'h1c000100,
                               32'h1c008000, 32'h1c008004, 32'h1c000200, 32'h1c000000};
  logic [31:0] exp_dlv [4] = '{32'h1c000000, 32'h1c000004, 32'h1c008000, 32'h1c000000};

  if_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .fs_flush_pipe     (fs_flush_pipe),
    .ex_target         (ex_target),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == RESET_PC) return 32'h02800421;
    return a ^ 32'h5a5a0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] exp_addr, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      #3;
      if (inst_sram_req) seen = 1'b1;
    end
    check({tag, "_req"}, 64'(inst_sram_req), 64'd1);
    if (seen) check(tag, 64'(inst_sram_addr), 64'(exp_addr));
  endtask

  // SRAM responder: addr_ok while idle, data_ok dok_lat cycles after the handshake.
  initial forever begin
    @(posedge clk);
    #2;
    if (hs) begin
      pend      = 1'b1;
      pend_cnt  = dok_lat;
      pend_addr = hs_addr;
      q_req.push_back(hs_addr);
    end
    inst_sram_data_ok = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = mem_rd(pend_addr);
        pend              = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    inst_sram_addr_ok = inst_sram_req && aok_en && !pend;
    hs                = inst_sram_addr_ok;
    hs_addr           = inst_sram_addr;
  end

  initial forever begin
    @(posedge clk);
    #3;
    if (fs_to_ds_valid && ds_allowin) q_dlv.push_back(fs_to_ds_bus);
  end

  initial begin
    resetn        = 1'b0;
    ds_allowin    = 1'b1;
    br_bus        = '0;
    fs_flush_pipe = 1'b0;
    ex_target     = 32'h0;
    aok_en        = 1'b1;
    dok_lat       = 1;

    step(); #3;
    step(); #3;
    check("rst_valid", 64'(fs_to_ds_valid), 64'd0);
    check("rst_req", 64'(inst_sram_req), 64'd0);

    step(); resetn = 1'b1; #3;
    check("first_req", 64'(inst_sram_req), 64'd1);
    check("first_addr", 64'(inst_sram_addr), 64'h1c000000);
    step(); #3;
    check("first_wait_valid", 64'(fs_to_ds_valid), 64'd0);

    // Decode stalls while the first instruction is held.
    for (int i = 0; i < 5; i++) begin
      step(); ds_allowin = 1'b0; #3;
      check("bp_valid", 64'(fs_to_ds_valid), 64'd1);
      check("bp_bus", fs_to_ds_bus, {32'h02800421, 32'h1c000000});
      check("bp_noreq", 64'(inst_sram_req), 64'd0);
    end
    step(); ds_allowin = 1'b1; #3;
    check("rel_valid", 64'(fs_to_ds_valid), 64'd1);
    check("rel_req", 64'(inst_sram_req), 64'd1);
    check("rel_addr", 64'(inst_sram_addr), 64'h1c000004);

    // Branch while waiting on 0x1c000008.
    wait_req(32'h1c000008, "seq_addr");
    dok_lat = 2;
    step(); br_bus = {1'b1, 32'h1c000100}; #3;
    check("br_wait_valid", 64'(fs_to_ds_valid), 64'd0);
    check("br_wait_noreq", 64'(inst_sram_req), 64'd0);
    step(); br_bus = '0; #3;
    check("br_drop_valid", 64'(fs_to_ds_valid), 64'd0);
    dok_lat = 1;
    step(); #3;
    check("br_tgt_valid", 64'(fs_to_ds_valid), 64'd0);
    check("br_tgt_req", 64'(inst_sram_req), 64'd1);
    check("br_tgt_addr", 64'(inst_sram_addr), 64'h1c000100);

    // Flush and branch together: flush target wins.
    step(); #3;
    step(); fs_flush_pipe = 1'b1; ex_target = 32'h1c008000; br_bus = {1'b1, 32'h1c000100}; #3;
    check("fl_valid", 64'(fs_to_ds_valid), 64'd0);
    check("fl_req", 64'(inst_sram_req), 64'd1);
    check("fl_addr", 64'(inst_sram_addr), 64'h1c008000);
    step(); fs_flush_pipe = 1'b0; ex_target = 32'h0; br_bus = '0; #3;

    // addr_ok withheld for 4 cycles while a branch pulses once.
    step(); aok_en = 1'b0; #3;
    check("fl_deliv_valid", 64'(fs_to_ds_valid), 64'd1);
    check("fl_deliv_bus", fs_to_ds_bus, {mem_rd(32'h1c008000), 32'h1c008000});
    check("stall_addr0", 64'(inst_sram_addr), 64'h1c008004);
    step(); br_bus = {1'b1, 32'h1c000200}; #3;
    check("stall_req1", 64'(inst_sram_req), 64'd1);
    check("stall_addr1", 64'(inst_sram_addr), 64'h1c008004);
    check("stall_valid1", 64'(fs_to_ds_valid), 64'd0);
    step(); br_bus = '0; #3;
    check("stall_addr2", 64'(inst_sram_addr), 64'h1c008004);
    step(); #3;
    check("stall_addr3", 64'(inst_sram_addr), 64'h1c008004);
    step(); aok_en = 1'b1; #3;
    check("stall_req4", 64'(inst_sram_req), 64'd1);
    check("stall_addr4", 64'(inst_sram_addr), 64'h1c008004);
    step(); #3;
    check("stale_drop_valid", 64'(fs_to_ds_valid), 64'd0);
    wait_req(32'h1c000200, "buf_target");

    // Reset during S_WAIT with the old data arriving late.
    dok_lat = 3;
    step(); resetn = 1'b0; #3;
    check("rst_wait_req", 64'(inst_sram_req), 64'd0);
    step(); resetn = 1'b1; dok_lat = 1; #3;
    check("rr_valid", 64'(fs_to_ds_valid), 64'd0);
    check("rr_req", 64'(inst_sram_req), 64'd1);
    check("rr_addr", 64'(inst_sram_addr), 64'h1c000000);
    step(); #3;
    check("stray_valid", 64'(fs_to_ds_valid), 64'd0);
    check("stray_addr", 64'(inst_sram_addr), 64'h1c000000);
    step(); #3;
    check("rr_wait_valid", 64'(fs_to_ds_valid), 64'd0);
    step(); #3;
    check("rr_deliv_valid", 64'(fs_to_ds_valid), 64'd1);
    check("rr_deliv_bus", fs_to_ds_bus, {32'h02800421, 32'h1c000000});

    check("req_count", 64'(q_req.size()), 64'd8);
    for (int i = 0; i < 8 && i < q_req.size(); i++)
      check($sformatf("req_log%0d", i), 64'(q_req[i]), 64'(exp_req[i]));
    check("dlv_count", 64'(q_dlv.size()), 64'd4);
    for (int i = 0; i < 4 && i < q_dlv.size(); i++)
      check($sformatf("dlv_log%0d", i), q_dlv[i], {mem_rd(exp_dlv[i]), exp_dlv[i]});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

endmodule
